// File: rtl/axi_pkg.sv
// Shared AXI encodings, read-slave FSM states and the burst next-address helper.
// Used by asi_r and intended for reuse by a matching write slave.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_t;

    // Address of the beat after cur; the reserved encoding falls through to INCR.
    function automatic logic [31:0] next_addr(
        input logic [31:0] cur,
        input logic [31:0] size,
        input logic [1:0]  burst,
        input logic [31:0] len
    );
        logic [31:0] step;
        logic [31:0] wrap_mask;
        step      = 32'd1 << size;
        wrap_mask = ((len + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: next_addr = cur;
            BURST_INCR:  next_addr = cur + step;
            BURST_WRAP:  next_addr = (cur & ~wrap_mask) | ((cur + step) & wrap_mask);
            default:     next_addr = cur + step;
        endcase
    endfunction

endpackage

// File: rtl/sfifo.sv
// Small synchronous FIFO with a show-ahead head so the consumer can pop and use q
// in the same cycle. Depth is 2**AW.
module sfifo #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          we,
    input  logic          re,
    input  logic [DW-1:0] d,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] q
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_reg [DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign q     = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (we && !full) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (we && !full) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (re && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/asi_r.sv
// AXI read slave: buffers AR requests, expands bursts into single-cycle user reads
// and returns beats through a 2-entry skid buffer. Optional ASI_R_BURST_CHECK_EN
// answers illegal bursts with SLVERR beats instead of reading the user port.
module asi_r
    import axi_pkg::*;
#(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 32,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AXI_RRESPW = 2,
    parameter int ASI_AD     = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [AXI_IW-1:0]     ARID,
    input  logic [AXI_AW-1:0]     ARADDR,
    input  logic [AXI_LW-1:0]     ARLEN,
    input  logic [AXI_SW-1:0]     ARSIZE,
    input  logic [AXI_BURSTW-1:0] ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [AXI_IW-1:0]     RID,
    output logic [AXI_DW-1:0]     RDATA,
    output logic [AXI_RRESPW-1:0] RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  usr_re,
    output logic [AXI_AW-1:0]     usr_raddr,
    input  logic [AXI_DW-1:0]     usr_rdata
);
    localparam int FIFO_AW = $clog2(ASI_AD);
    localparam int AR_W    = AXI_IW + AXI_AW + AXI_LW + AXI_SW + AXI_BURSTW;

    // AR request buffer
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_re;
    logic                  ar_push;
    logic [AR_W-1:0]       ar_d;
    logic [AR_W-1:0]       ar_q;
    logic [AXI_IW-1:0]     ar_id;
    logic [AXI_AW-1:0]     ar_addr;
    logic [AXI_LW-1:0]     ar_len;
    logic [AXI_SW-1:0]     ar_size;
    logic [AXI_BURSTW-1:0] ar_burst;
    logic                  ar_err;

    assign ARREADY = !fifo_full && !ARESET;
    assign ar_push = ARVALID && ARREADY;
    assign ar_d    = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
    assign {ar_id, ar_addr, ar_len, ar_size, ar_burst} = ar_q;

    sfifo #(
        .AW (FIFO_AW),
        .DW (AR_W)
    ) u_ar_fifo (
        .clk   (ACLK),
        .srst  (ARESET),
        .we    (ar_push),
        .re    (fifo_re),
        .d     (ar_d),
        .full  (fifo_full),
        .empty (fifo_empty),
        .q     (ar_q)
    );

`ifdef ASI_R_BURST_CHECK_EN
    localparam int SIZE_MAX = $clog2(AXI_DW / 8);

    always_comb begin
        ar_err = 1'b0;
        if (2'(ar_burst) == 2'd3) begin
            ar_err = 1'b1;
        end
        if (2'(ar_burst) == BURST_WRAP &&
            !(ar_len == AXI_LW'(1) || ar_len == AXI_LW'(3) ||
              ar_len == AXI_LW'(7) || ar_len == AXI_LW'(15))) begin
            ar_err = 1'b1;
        end
        if (ar_size > AXI_SW'(SIZE_MAX)) begin
            ar_err = 1'b1;
        end
    end
`else
    assign ar_err = 1'b0;
`endif

    // Burst engine state
    rd_state_t             state_reg;
    rd_state_t             state_next;
    logic [AXI_IW-1:0]     id_reg;
    logic [AXI_AW-1:0]     addr_reg;
    logic [AXI_AW-1:0]     addr_next;
    logic [AXI_LW-1:0]     len_reg;
    logic [AXI_SW-1:0]     size_reg;
    logic [AXI_BURSTW-1:0] burst_reg;
    logic [AXI_LW-1:0]     beat_cnt_reg;
    logic                  err_reg;
    logic                  last_beat;
    logic                  permit;
    logic                  issue;

    // Read-data pipeline stage (the beat whose user data arrives this cycle)
    logic                  pipe_valid_reg;
    logic [AXI_IW-1:0]     pipe_id_reg;
    logic                  pipe_err_reg;
    logic                  pipe_last_reg;
    logic [AXI_DW-1:0]     pipe_data;
    logic [AXI_RRESPW-1:0] pipe_resp;

    // Skid buffer
    logic [AXI_IW-1:0]     skid_id_reg   [2];
    logic [AXI_DW-1:0]     skid_data_reg [2];
    logic [AXI_RRESPW-1:0] skid_resp_reg [2];
    logic                  skid_last_reg [2];
    logic                  skid_wr_reg;
    logic                  skid_rd_reg;
    logic [1:0]            skid_cnt_reg;
    logic                  skid_push;
    logic                  skid_pop;
    logic                  r_pop;
    logic [1:0]            occ;

    assign fifo_re   = (state_reg == ST_IDLE) && !fifo_empty;
    assign last_beat = (beat_cnt_reg == len_reg);
    assign r_pop     = RVALID && RREADY;
    assign occ       = skid_cnt_reg + {1'b0, pipe_valid_reg};
    // A beat may issue only if it is guaranteed a skid slot when its data returns.
    assign permit    = (occ < 2'd2) || (occ == 2'd2 && r_pop);
    assign issue     = (state_reg == ST_BURST) && permit;
    assign addr_next = AXI_AW'(next_addr(32'(addr_reg), 32'(size_reg),
                                         2'(burst_reg), 32'(len_reg)));

    assign usr_re    = issue && !err_reg;
    assign usr_raddr = usr_re ? addr_reg : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (!fifo_empty) state_next = ST_BURST;
            ST_BURST: if (issue && last_beat) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg      <= ST_IDLE;
            id_reg         <= '0;
            addr_reg       <= '0;
            len_reg        <= '0;
            size_reg       <= '0;
            burst_reg      <= '0;
            beat_cnt_reg   <= '0;
            err_reg        <= 1'b0;
            pipe_valid_reg <= 1'b0;
            pipe_id_reg    <= '0;
            pipe_err_reg   <= 1'b0;
            pipe_last_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pipe_valid_reg <= issue;
            if (issue) begin
                pipe_id_reg   <= id_reg;
                pipe_err_reg  <= err_reg;
                pipe_last_reg <= last_beat;
            end
            if (fifo_re) begin
                id_reg       <= ar_id;
                addr_reg     <= ar_addr;
                len_reg      <= ar_len;
                size_reg     <= ar_size;
                burst_reg    <= ar_burst;
                beat_cnt_reg <= '0;
                err_reg      <= ar_err;
            end else if (issue) begin
                addr_reg     <= addr_next;
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
        end
    end

    assign pipe_data = pipe_err_reg ? '0 : usr_rdata;
    assign pipe_resp = pipe_err_reg ? AXI_RRESPW'(RESP_SLVERR) : AXI_RRESPW'(RESP_OKAY);

    // With the skid empty, the pipeline beat is presented directly; it only lands
    // in the skid when the master stalls it.
    assign skid_push = pipe_valid_reg && !(skid_cnt_reg == 2'd0 && RREADY);
    assign skid_pop  = (skid_cnt_reg != 2'd0) && RREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            skid_wr_reg  <= 1'b0;
            skid_rd_reg  <= 1'b0;
            skid_cnt_reg <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                skid_id_reg[i]   <= '0;
                skid_data_reg[i] <= '0;
                skid_resp_reg[i] <= '0;
                skid_last_reg[i] <= 1'b0;
            end
        end else begin
            if (skid_push) begin
                skid_id_reg[skid_wr_reg]   <= pipe_id_reg;
                skid_data_reg[skid_wr_reg] <= pipe_data;
                skid_resp_reg[skid_wr_reg] <= pipe_resp;
                skid_last_reg[skid_wr_reg] <= pipe_last_reg;
                skid_wr_reg                <= ~skid_wr_reg;
            end
            if (skid_pop) begin
                skid_rd_reg <= ~skid_rd_reg;
            end
            skid_cnt_reg <= skid_cnt_reg + 2'(skid_push) - 2'(skid_pop);
        end
    end

    always_comb begin
        RVALID = 1'b0;
        RID    = '0;
        RDATA  = '0;
        RRESP  = '0;
        RLAST  = 1'b0;
        if (skid_cnt_reg != 2'd0) begin
            RVALID = 1'b1;
            RID    = skid_id_reg[skid_rd_reg];
            RDATA  = skid_data_reg[skid_rd_reg];
            RRESP  = skid_resp_reg[skid_rd_reg];
            RLAST  = skid_last_reg[skid_rd_reg];
        end else if (pipe_valid_reg) begin
            RVALID = 1'b1;
            RID    = pipe_id_reg;
            RDATA  = pipe_data;
            RRESP  = pipe_resp;
            RLAST  = pipe_last_reg;
        end
    end

endmodule

// File: tb/tb_asi_r.sv
// Scoreboard bench for asi_r: AR requests push expected addresses and beats,
// a negedge monitor pops and compares user reads and R beats.
module tb_asi_r;

    logic         ACLK;
    logic         ARESET;
    logic [7:0]   ARID;
    logic [31:0]  ARADDR;
    logic [7:0]   ARLEN;
    logic [2:0]   ARSIZE;
    logic [1:0]   ARBURST;
    logic         ARVALID;
    logic         ARREADY;
    logic [7:0]   RID;
    logic [127:0] RDATA;
    logic [1:0]   RRESP;
    logic         RLAST;
    logic         RVALID;
    logic         RREADY;
    logic         usr_re;
    logic [31:0]  usr_raddr;
    logic [127:0] usr_rdata;

    typedef struct {
        logic [7:0]   id;
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] addr_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    bit           occ_chk_en = 0;
    int           issued     = 0;
    int           accepted   = 0;
    bit           prev_stall = 0;
    logic [127:0] prev_data;
    logic [7:0]   prev_id;
    logic         prev_last;

    asi_r u_dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .ARID      (ARID),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RID       (RID),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .usr_re    (usr_re),
        .usr_raddr (usr_raddr),
        .usr_rdata (usr_rdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] mem_f(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a, ~a, a + 32'h1234_5678};
    endfunction

    // User memory: data one cycle after the strobe, junk otherwise.
    always @(posedge ACLK) begin
        if (usr_re) usr_rdata <= mem_f(usr_raddr);
        else        usr_rdata <= {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int len,
                                             input int size, input logic [1:0] burst,
                                             input int beat);
        logic [31:0] step;
        logic [31:0] win;
        logic [31:0] lo;
        step = 32'd1 << size;
        if (burst == 2'd0) return base;
        if (burst == 2'd2) begin
            win = 32'(len + 1) * step;
            lo  = base - (base % win);
            return lo + ((base - lo + 32'(beat) * step) % win);
        end
        return base + 32'(beat) * step;
    endfunction

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic  hs;
        bit    done;
        bit    err;
        beat_t e;
        logic [31:0] a;
        done    = 0;
        ARID    = id;
        ARADDR  = addr;
        ARLEN   = len;
        ARSIZE  = size;
        ARBURST = burst;
        ARVALID = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge ACLK);
            hs = ARREADY;
            @(posedge ACLK);
            if (hs) done = 1;
        end
        #1;
        ARVALID = 1'b0;
        if (!done) begin
            chk("ar_handshake", {127'd0, done}, 128'd1);
            return;
        end
`ifdef ASI_R_BURST_CHECK_EN
        err = (burst == 2'd3) || (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15))
              || (size > 3'd4);
`else
        err = 0;
`endif
        $display("[TB] AR id=%0h addr=%0h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
        for (int b = 0; b <= int'(len); b++) begin
            a = exp_addr(addr, int'(len), int'(size), burst, b);
            if (!err) addr_q.push_back(a);
            e.id   = id;
            e.data = err ? 128'd0 : mem_f(a);
            e.resp = err ? 2'd2 : 2'd0;
            e.last = (b == int'(len));
            exp_q.push_back(e);
        end
    endtask

    // Monitor: sampled on the falling edge, between input updates and the next active edge.
    always @(negedge ACLK) begin
        beat_t e;
        int    occ;
        if (ARESET) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {127'd0, RVALID}, 128'd1);
                chk("stall_data", RDATA, prev_data);
                chk("stall_id", {120'd0, RID}, {120'd0, prev_id});
                chk("stall_last", {127'd0, RLAST}, {127'd0, prev_last});
            end
            if (usr_re) begin
                if (occ_chk_en) begin
                    occ = issued - accepted;
                    chk("issue_permit", {127'd0, (occ < 2) || (occ == 2 && RVALID && RREADY)}, 128'd1);
                    issued++;
                end
                if (addr_q.size() == 0) chk("addr_unexp", 128'(addr_q.size()), 128'd1);
                else chk("usr_raddr", {96'd0, usr_raddr}, {96'd0, addr_q.pop_front()});
            end
            if (RVALID && RREADY) begin
                if (occ_chk_en) accepted++;
                $display("[TB] R id=%0h resp=%0d last=%0b data=%h", RID, RRESP, RLAST, RDATA);
                if (exp_q.size() == 0) begin
                    chk("r_unexp", 128'(exp_q.size()), 128'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rid", {120'd0, RID}, {120'd0, e.id});
                    chk("rdata", RDATA, e.data);
                    chk("rresp", {126'd0, RRESP}, {126'd0, e.resp});
                    chk("rlast", {127'd0, RLAST}, {127'd0, e.last});
                end
            end
            prev_stall = RVALID && !RREADY;
            prev_data  = RDATA;
            prev_id    = RID;
            prev_last  = RLAST;
        end
    end

    task automatic drain(input bit toggle);
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && addr_q.size() == 0) break;
            @(posedge ACLK);
            #1;
            if (toggle) RREADY = (i % 4 == 3) || (i % 4 == 2);
        end
        chk("drain_r", 128'(exp_q.size()), 128'd0);
        chk("drain_addr", 128'(addr_q.size()), 128'd0);
        RREADY = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    logic lat_re[7];
    logic lat_rv[7];

    initial begin
        ARESET  = 1'b1;
        ARID    = '0;
        ARADDR  = '0;
        ARLEN   = '0;
        ARSIZE  = '0;
        ARBURST = '0;
        ARVALID = 1'b0;
        RREADY  = 1'b0;

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_arready", {127'd0, ARREADY}, 128'd0);
        chk("rst_rvalid", {127'd0, RVALID}, 128'd0);
        chk("rst_usr_re", {127'd0, usr_re}, 128'd0);
        chk("rst_rdata", RDATA, 128'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        RREADY = 1'b1;
        @(negedge ACLK);
        chk("post_rst_arready", {127'd0, ARREADY}, 128'd1);
        @(posedge ACLK);
        #1;

        // INCR with latency profile: first negedge after the AR edge is k=0
        send_ar(8'h01, 32'h100, 8'd3, 3'd4, 2'd1);
        for (int k = 0; k < 7; k++) begin
            @(negedge ACLK);
            lat_re[k] = usr_re;
            lat_rv[k] = RVALID;
        end
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("lat_usr_re%0d", k), {127'd0, lat_re[k]}, {127'd0, (k >= 1 && k <= 4)});
            chk($sformatf("lat_rvalid%0d", k), {127'd0, lat_rv[k]}, {127'd0, (k >= 2 && k <= 5)});
        end
        @(posedge ACLK);
        #1;
        drain(0);

        // WRAP within a 64-byte window, then FIXED
        send_ar(8'h02, 32'h38, 8'd3, 3'd4, 2'd2);
        send_ar(8'h03, 32'h40, 8'd2, 3'd4, 2'd0);
        drain(0);

        // Backpressure on an 8-beat INCR
        issued     = 0;
        accepted   = 0;
        occ_chk_en = 1;
        send_ar(8'h04, 32'h1000, 8'd7, 3'd4, 2'd1);
        drain(1);
        occ_chk_en = 0;

        // AR buffer fill with R stalled: one burst in the engine plus four buffered
        RREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_ar(8'h10 + 8'(i), 32'h2000 + 32'(i) * 32'h100, 8'd3, 3'd4, 2'd1);
        end
        @(negedge ACLK);
        chk("ar_full", {127'd0, ARREADY}, 128'd0);
        @(posedge ACLK);
        #1;
        RREADY = 1'b1;
        drain(0);

        // Reset in the middle of a 4-beat burst
        send_ar(8'h20, 32'h3000, 8'd3, 3'd4, 2'd1);
        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        exp_q.delete();
        addr_q.delete();
        @(negedge ACLK);
        chk("midrst_rvalid", {127'd0, RVALID}, 128'd0);
        chk("midrst_arready", {127'd0, ARREADY}, 128'd0);
        chk("midrst_usr_re", {127'd0, usr_re}, 128'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;
        send_ar(8'h21, 32'h4000, 8'd3, 3'd4, 2'd1);
        drain(0);

        // Reserved burst encoding: SLVERR beats when checked, INCR otherwise
        send_ar(8'h77, 32'h200, 8'd1, 3'd4, 2'd3);
        drain(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
